bcp_scheduler: RTL and testbench

BCP_SCHEDULER -- requirements
Module: bcp_scheduler

---
 rtl/bcp_scheduler_pkg.sv | 30 +++
 rtl/bcp_clause_table.sv | 49 ++++
 rtl/bcp_scheduler.sv | 178 +++++++++++++++++
 tb/tb_bcp_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcp_scheduler_pkg
//  Description : Shared definitions for the BCP scheduler: default sizes,
//                the sweep FSM state encoding and the clause record layout.
//  Revision    : 1.0  initial release
// ============================================================================
package bcp_scheduler_pkg;

    localparam int VAR_NUM_DEF    = 8;
    localparam int CLAUSE_NUM_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_CHECK = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // One clause slot at the default variable count.
    typedef struct packed {
        logic [VAR_NUM_DEF-1:0] typ;
        logic [VAR_NUM_DEF-1:0] mask;
        logic [VAR_NUM_DEF-1:0] size;
    } clause_t;

endpackage
`default_nettype wire

// File: rtl/bcp_clause_table.sv
`default_nettype none
// ============================================================================
//  Module      : bcp_clause_table
//  Description : Local clause table. Register array with one synchronous
//                write port and one asynchronous read port.
//  Ports       : clock, reset (async, active-low)
//                we, wr_addr, wr_type, wr_mask, wr_size  -- write port
//                rd_addr -> rd_type, rd_mask, rd_size     -- read port
//  Revision    : 1.0  initial release
// ============================================================================
module bcp_clause_table
    import bcp_scheduler_pkg::*;
#(
    parameter int VAR_NUM    = VAR_NUM_DEF,
    parameter int CLAUSE_NUM = CLAUSE_NUM_DEF,
    localparam int IDX_W     = $clog2(CLAUSE_NUM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [VAR_NUM-1:0] wr_type,
    input  logic [VAR_NUM-1:0] wr_mask,
    input  logic [VAR_NUM-1:0] wr_size,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [VAR_NUM-1:0] rd_type,
    output logic [VAR_NUM-1:0] rd_mask,
    output logic [VAR_NUM-1:0] rd_size
);

    // Entry layout: {type, mask, size}
    logic [3*VAR_NUM-1:0] mem [CLAUSE_NUM];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CLAUSE_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= {wr_type, wr_mask, wr_size};
        end
    end

    assign rd_type = mem[rd_addr][3*VAR_NUM-1:2*VAR_NUM];
    assign rd_mask = mem[rd_addr][2*VAR_NUM-1:VAR_NUM];
    assign rd_size = mem[rd_addr][VAR_NUM-1:0];

endmodule
`default_nettype wire

// File: rtl/bcp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bcp_scheduler
//  Description : Sweeps the local clause table slot by slot, driving an
//                external unit-clause checker (load, then evaluate for
//                max(size,1) cycles, then sample its result). Stops at the
//                first slot reporting a unit clause or after the last slot.
//  Ports       : clock, reset (async, active-low)
//                cfg_we/cfg_addr/cfg_type/cfg_mask/cfg_size -- table write
//                start, abort                               -- sweep control
//                chk_init, chk_en, chk_type/mask/size       -- to checker
//                chk_unit_exist                             -- from checker
//                busy, done, unit_found, unit_idx           -- status/result
//  Options     : BCP_SKIP_EMPTY_EN -- slots with mask==0 are skipped in
//                LOAD (no chk_init, straight to NEXT).
//  Revision    : 1.0  initial release
// ============================================================================
module bcp_scheduler
    import bcp_scheduler_pkg::*;
#(
    parameter int VAR_NUM    = VAR_NUM_DEF,
    parameter int CLAUSE_NUM = CLAUSE_NUM_DEF,
    localparam int IDX_W     = $clog2(CLAUSE_NUM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [VAR_NUM-1:0] cfg_type,
    input  logic [VAR_NUM-1:0] cfg_mask,
    input  logic [VAR_NUM-1:0] cfg_size,
    input  logic               start,
    input  logic               abort,
    output logic               chk_init,
    output logic               chk_en,
    output logic [VAR_NUM-1:0] chk_type,
    output logic [VAR_NUM-1:0] chk_mask,
    output logic [VAR_NUM-1:0] chk_size,
    input  logic               chk_unit_exist,
    output logic               busy,
    output logic               done,
    output logic               unit_found,
    output logic [IDX_W-1:0]   unit_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLAUSE_NUM - 1);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [VAR_NUM-1:0] ecnt;
    logic [IDX_W-1:0]   load_addr;
    logic [VAR_NUM-1:0] rd_type;
    logic [VAR_NUM-1:0] rd_mask;
    logic [VAR_NUM-1:0] rd_size;
    logic               abort_hit;

    // The table is read at the slot about to be loaded so the checker
    // fields are already registered during the LOAD cycle itself.
    assign load_addr = (state == ST_IDLE) ? '0 : idx + 1'b1;
    assign abort_hit = abort && (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);

    bcp_clause_table #(
        .VAR_NUM    (VAR_NUM),
        .CLAUSE_NUM (CLAUSE_NUM)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .we      (cfg_we),
        .wr_addr (cfg_addr),
        .wr_type (cfg_type),
        .wr_mask (cfg_mask),
        .wr_size (cfg_size),
        .rd_addr (load_addr),
        .rd_type (rd_type),
        .rd_mask (rd_mask),
        .rd_size (rd_size)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        chk_init   = 1'b0;
        chk_en     = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
`ifdef BCP_SKIP_EMPTY_EN
                if (chk_mask == '0) begin
                    next_state = ST_NEXT;
                end else begin
                    chk_init   = 1'b1;
                    next_state = ST_EVAL;
                end
`else
                chk_init   = 1'b1;
                next_state = ST_EVAL;
`endif
            end
            ST_EVAL: begin
                chk_en = 1'b1;
                if ((ecnt == chk_size) || (chk_size == '0)) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                next_state = chk_unit_exist ? ST_DONE : ST_NEXT;
            end
            ST_NEXT: begin
                next_state = (idx == LAST_IDX) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        // Abort overrides every transition and suppresses the done pulse.
        if (abort_hit) begin
            next_state = ST_IDLE;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            ecnt       <= '0;
            chk_type   <= '0;
            chk_mask   <= '0;
            chk_size   <= '0;
            unit_found <= 1'b0;
            unit_idx   <= '0;
        end else begin
            if ((state == ST_IDLE) && (next_state == ST_LOAD)) begin
                idx        <= '0;
                unit_found <= 1'b0;
            end
            if ((state == ST_NEXT) && (next_state == ST_LOAD)) begin
                idx <= idx + 1'b1;
            end
            if (next_state == ST_LOAD) begin
                chk_type <= rd_type;
                chk_mask <= rd_mask;
                chk_size <= rd_size;
            end
            if (state == ST_LOAD) begin
                ecnt <= {{(VAR_NUM-1){1'b0}}, 1'b1};
            end else if ((state == ST_EVAL) && (ecnt != '1)) begin
                ecnt <= ecnt + 1'b1;
            end
            if ((state == ST_CHECK) && (next_state == ST_DONE)) begin
                unit_found <= 1'b1;
                unit_idx   <= idx;
            end
            if (abort_hit) begin
                unit_found <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcp_scheduler
//  Description : Scoreboard bench for bcp_scheduler. A sweep-level model
//                queues the expected checker loads and final result; a
//                monitor pops and compares whenever the DUT loads the
//                checker or signals done.
//  Options     : BCP_SKIP_EMPTY_EN -- must match the RTL build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcp_scheduler;
    import bcp_scheduler_pkg::*;

    localparam int VN = 8;
    localparam int CN = 8;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [VN-1:0] cfg_type = '0;
    logic [VN-1:0] cfg_mask = '0;
    logic [VN-1:0] cfg_size = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          chk_unit_exist = 1'b0;
    logic          chk_init, chk_en, busy, done, unit_found;
    logic [VN-1:0] chk_type, chk_mask, chk_size;
    logic [IW-1:0] unit_idx;

    bcp_scheduler #(.VAR_NUM(VN), .CLAUSE_NUM(CN)) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_type       (cfg_type),
        .cfg_mask       (cfg_mask),
        .cfg_size       (cfg_size),
        .start          (start),
        .abort          (abort),
        .chk_init       (chk_init),
        .chk_en         (chk_en),
        .chk_type       (chk_type),
        .chk_mask       (chk_mask),
        .chk_size       (chk_size),
        .chk_unit_exist (chk_unit_exist),
        .busy           (busy),
        .done           (done),
        .unit_found     (unit_found),
        .unit_idx       (unit_idx)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            is_done;
        clause_t       cl;
        int            evals;
        bit            unit;
        bit            found;
        logic [IW-1:0] uidx;
    } exp_t;

    exp_t          exp_q[$];
    clause_t       tbl[CN];
    logic [IW-1:0] last_uidx = '0;
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            init_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    exp_t em;
    int   pend = -1;
    int   ecount = 0;

    always @(negedge clock) begin
        if (chk_init || chk_en) chk("init_en_exclusive", {31'd0, chk_init & chk_en}, 0);
        if (!busy) begin
            pend = -1;
            chk_unit_exist = 1'b0;
        end
        if (chk_init) begin
            init_cnt++;
            if (pend >= 0) chk("eval_cycles", ecount, pend);
            pend = -1;
            if (exp_q.size() == 0) begin
                chk("unexpected_load", {31'd0, exp_q.size() == 0}, 0);
            end else begin
                em = exp_q.pop_front();
                chk("load_kind", {31'd0, em.is_done}, 0);
                chk("chk_type", chk_type, em.cl.typ);
                chk("chk_mask", chk_mask, em.cl.mask);
                chk("chk_size", chk_size, em.cl.size);
                pend = em.evals;
                ecount = 0;
                chk_unit_exist = em.unit;
            end
        end
        if (chk_en) ecount++;
        if (done) begin
            done_cnt++;
            if (pend >= 0) chk("eval_cycles_last", ecount, pend);
            pend = -1;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'd0, exp_q.size() == 0}, 0);
            end else begin
                em = exp_q.pop_front();
                chk("done_kind", {31'd0, em.is_done}, 1);
                chk("unit_found", {31'd0, unit_found}, {31'd0, em.found});
                chk("unit_idx", unit_idx, em.uidx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: expected events of one sweep from the table and
    // the per-slot checker answers.
    // ------------------------------------------------------------------
    task automatic expect_sweep(input bit [CN-1:0] uv, output int nloads);
        exp_t e;
        bit   found = 1'b0;
        nloads = 0;
        for (int s = 0; s < CN; s++) begin
`ifdef BCP_SKIP_EMPTY_EN
            if (tbl[s].mask == '0) continue;
`endif
            e = '{default: '0};
            e.cl    = tbl[s];
            e.evals = (tbl[s].size == 0) ? 1 : int'(tbl[s].size);
            e.unit  = uv[s];
            exp_q.push_back(e);
            nloads++;
            if (uv[s]) begin
                found = 1'b1;
                last_uidx = IW'(s);
                break;
            end
        end
        e = '{default: '0};
        e.is_done = 1'b1;
        e.found   = found;
        e.uidx    = last_uidx;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input int a, input logic [VN-1:0] t, input logic [VN-1:0] m,
                             input logic [VN-1:0] s);
        cfg_we = 1'b1; cfg_addr = IW'(a); cfg_type = t; cfg_mask = m; cfg_size = s;
        tbl[a].typ = t; tbl[a].mask = m; tbl[a].size = s;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic begin_sweep(input bit [CN-1:0] uv, output int nl, output int i0, output int d0);
        expect_sweep(uv, nl);
        i0 = init_cnt;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic end_sweep(input int nl, input int i0, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            tick();
            n++;
        end
        chk("sweep_completes", {31'd0, done_cnt != d0}, 1);
        tick();
        tick();
        chk("loads_per_sweep", init_cnt - i0, nl);
        chk("done_pulses", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_after_sweep", {31'd0, busy}, 0);
        exp_q.delete();
    endtask

    task automatic run_sweep(input bit [CN-1:0] uv);
        int nl, i0, d0;
        begin_sweep(uv, nl, i0, d0);
        end_sweep(nl, i0, d0);
    endtask

    task automatic wait_eval_of(input int target, input int i0);
        int n = 0;
        while (!(init_cnt >= i0 + target && chk_en) && n < 500) begin
            tick();
            n++;
        end
        chk("reached_eval", {31'd0, chk_en}, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_chk_init"}, {31'd0, chk_init}, 0);
        chk({tag, "_chk_en"}, {31'd0, chk_en}, 0);
        chk({tag, "_fields"}, {8'd0, chk_type, chk_mask, chk_size}, 0);
        chk({tag, "_unit_found"}, {31'd0, unit_found}, 0);
        chk({tag, "_unit_idx"}, unit_idx, 0);
    endtask

    task automatic random_table();
        for (int s = 0; s < CN; s++) begin
            cfg_write(s, VN'($urandom),
                      ($urandom_range(0, 3) == 0) ? '0 : VN'($urandom | 1),
                      VN'($urandom_range(0, 4)));
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int nl, i0, d0;
        logic [VN-1:0] old_t, old_m, old_s;

        for (int s = 0; s < CN; s++) tbl[s] = '0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Only slot 0 populated, checker never reports a unit.
        cfg_write(0, 8'h00, 8'h00, 8'd2);
        run_sweep('0);

        // Unit reported in slot 3; later slots are never loaded.
        cfg_write(3, 8'h33, 8'h0F, 8'd3);
        run_sweep(8'b0000_1000);

        // Start while busy and a write to the active slot mid-sweep.
        random_table();
        cfg_write(0, 8'h5A, 8'hC3, 8'd3);
        begin_sweep('0, nl, i0, d0);
        wait_eval_of(1, i0);
        old_t = tbl[0].typ; old_m = tbl[0].mask; old_s = tbl[0].size;
        cfg_write(0, 8'hA5, 8'h3C, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("held_type", chk_type, old_t);
        chk("held_mask", chk_mask, old_m);
        chk("held_size", chk_size, old_s);
        end_sweep(nl, i0, d0);
        run_sweep(8'b0000_0001);

        // Abort during EVAL of slot 2.
        for (int s = 0; s < CN; s++) cfg_write(s, VN'(8'h10 + s), 8'hFF, 8'd3);
        begin_sweep('0, nl, i0, d0);
        wait_eval_of(3, i0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_chk_en", {31'd0, chk_en}, 0);
        chk("abort_unit_found", {31'd0, unit_found}, 0);
        repeat (4) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        run_sweep(8'b0100_0000);

        // Reset in the middle of EVAL.
        random_table();
        cfg_write(1, 8'h77, 8'h01, 8'd4);
        begin_sweep('0, nl, i0, d0);
        wait_eval_of(2, i0);
        reset = 1'b0;
        #2;
        check_all_zero("async_reset");
        exp_q.delete();
        for (int s = 0; s < CN; s++) tbl[s] = '0;
        last_uidx = '0;
        d0 = done_cnt;
        tick();
        reset = 1'b1;
        tick();
        chk("reset_no_done", done_cnt - d0, 0);
        cfg_write(6, 8'h66, 8'h81, 8'd2);
        run_sweep(8'b0100_0000);

        // Only slot 5 nonzero.
        for (int s = 0; s < CN; s++) cfg_write(s, '0, '0, '0);
        cfg_write(5, 8'hA5, 8'h3C, 8'd2);
        run_sweep('0);

        // Randomized sweeps.
        for (int it = 0; it < 20; it++) begin
            random_table();
            run_sweep(CN'($urandom & $urandom & $urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
